sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Controller for a single-port masked SRAM macro: 4096 x 96 bits, 16 write-mask lanes of 6 bits each, read data returned 1 cycle after the read.
- Shares the macro's one read/write port between an independent read requester and an independent write requester.
- After reset, and on request, sweeps the whole array to a known value; requesters are blocked until the sweep finishes.
- Sits between pipeline-side request logic and the SRAM macro instance.

Parameters:
ADDR_W, 12, SRAM address width; depth = 2^ADDR_W
DATA_W, 96, SRAM data width
MASK_W, 16, write-mask lanes; lane width = DATA_W/MASK_W
STARVE_LIMIT, 4, consecutive write-won conflicts before the read is forced through (1..15)
INIT_VAL, 0, per-entry value written by the sweep (DATA_W bits)

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high reset
clear_req  in  1  pulse; re-runs the sweep
init_done  out  1  high when the sweep is finished and requests are accepted
wreq_valid  in  1  write request
wreq_ready  out  1  write accepted this cycle
wreq_addr  in  ADDR_W  write address
wreq_mask  in  MASK_W  lane enables
wreq_data  in  DATA_W  write data
rreq_valid  in  1  read request
rreq_ready  out  1  read accepted this cycle
rreq_addr  in  ADDR_W  read address
rresp_valid  out  1  read data valid
rresp_data  out  DATA_W  read data
sram_addr  out  ADDR_W  to macro
sram_en  out  1  to macro
sram_wmode  out  1  to macro; 1 = write
sram_wmask  out  MASK_W  to macro
sram_wdata  out  DATA_W  to macro
sram_rdata  in  DATA_W  from macro

Behaviour:
- Interface: one clock, `clock`. `reset` is synchronous and active-high; it is sampled only on the rising edge of `clock`.
- Reset values:
  - state = INIT, sweep pointer = 0.
  - init_done = 0, rreq_ready = 0, wreq_ready = 0, rresp_valid = 0.
  - starve_cnt = 0.
- FSM state INIT:
  - Each cycle drive sram_en=1, sram_wmode=1, sram_wmask=all-ones, sram_wdata=INIT_VAL, sram_addr=pointer.
  - Pointer increments each cycle.
  - On the cycle writing address 2^ADDR_W-1, next state = READY and pointer returns to 0.
  - The sweep takes exactly 4096 cycles; init_done rises in cycle 4097 after reset deassert.
  - Both ready outputs are 0 throughout.
- FSM state READY:
  - init_done = 1.
  - clear_req = 1 moves next state to INIT with pointer = 0. No request is granted in the cycle clear_req is sampled high.
  - clear_req during INIT is ignored; the sweep is not restarted.
- Arbitration in READY (combinational grant, same cycle):
  - Only one valid: grant it.
  - Both valid: grant the write, unless starve_cnt == STARVE_LIMIT, in which case grant the read.
  - rreq_ready and wreq_ready are never both 1.
  - The ready outputs may depend combinationally on the valids.
  - A requester must hold valid and payload stable until ready.
- starve_cnt:
  - Increments on each cycle where both are valid and the write wins.
  - Clears on any read grant, or when rreq_valid = 0.
  - Saturates at STARVE_LIMIT.
- Grant to macro:
  - Write grant: sram_en=1, sram_wmode=1, payload passed through unchanged.
  - Read grant: sram_en=1, sram_wmode=0, sram_addr=rreq_addr.
  - No grant: sram_en=0; other sram_* outputs are don't-care but are driven to 0.
- Read response:
  - rresp_valid is registered: 1 exactly one cycle after a read grant.
  - rresp_data = sram_rdata, combinational, and is meaningful only while rresp_valid = 1.
  - No internal data buffering. The consumer must take the data in that cycle; there is no backpressure.
- Ordering and hazards:
  - A write granted in the cycle after a read grant to the same address does not corrupt that read's response, because the macro updates at the edge ending the response cycle.
  - Read then write, or write then read, to the same address: a read granted after a write returns the new data.
- Reset mid-sweep: pointer returns to 0 and the sweep restarts.
- Reset while a response is due: rresp_valid = 0 the next cycle.
- clear_req while a response is due: the response is still delivered (rresp_valid = 1) in the first INIT cycle.

Decomposition:
- Shared package holds:
  - ADDR_W, DATA_W, MASK_W defaults.
  - State enum {INIT, READY}.
  - Typedefs for the write request struct (addr, mask, data) and the read request struct.
- One natural sub-module, `sram_init_sweeper`: pointer counter plus done flag, with start and last-address outputs.
- Arbitration and starvation counter stay in the top module.

Test Plan:
- Reset, then idle: init_done = 0 for 4096 cycles and 1 in cycle 4097. sram_en = 1, wmode = 1, mask = 16'hFFFF on every sweep cycle; addresses run 0 to 4095 in order.
- Write addr 12'h0A5, mask 16'h0001, data 96'h3F -> one write cycle. Then read 12'h0A5 -> rresp_valid one cycle later with data 96'h3F (lane 0 only, other lanes INIT_VAL).
- Both valid continuously with STARVE_LIMIT = 4 -> grant pattern W,W,W,W,R repeating. No cycle has both readies high.
- Read 12'h010 in cycle t, then write 12'h010 = all-ones in cycle t+1 -> response in t+1 returns the old value. A read in t+2 returns the new value in t+3.
- clear_req in cycle t while a read response is due in t+1 -> rresp_valid = 1 in t+1. init_done = 0 from t+1 for 4096 cycles. After init_done returns, all previously written addresses read back INIT_VAL.
- reset asserted at sweep address 2000 -> next cycle writes address 0. init_done is reached 4096 cycles after reset deassert.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and default widths for the SRAM port arbiter and its sweeper.
package sram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 96;
    localparam int MASK_W_DEF = 16;

    // INIT: sweeping the array, requesters blocked. READY: arbitrating requests.
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [MASK_W_DEF-1:0] mask;
        logic [DATA_W_DEF-1:0] data;
    } wreq_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
    } rreq_t;

endpackage

// File: rtl/sram_init_sweeper.sv
// Address pointer for the array sweep. It advances while run is high, flags the
// last address, and latches done once the last address has been written.
module sram_init_sweeper
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              run,
    output logic [ADDR_W-1:0] ptr,
    output logic              last,
    output logic              done
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;

    // Pointer steps once per sweep cycle; wrapping past the top address lands on 0.
    always_comb begin
        ptr_d  = ptr_q;
        done_d = done_q;
        last   = run && (ptr_q == '1);
        if (start) begin
            ptr_d  = '0;
            done_d = 1'b0;
        end else if (run) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (last) begin
                done_d = 1'b1;
            end
        end
    end

    // Pointer and done flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q  <= '0;
            done_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            done_q <= done_d;
        end
    end

    assign ptr  = ptr_q;
    assign done = done_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port masked SRAM between a read and a write requester.
// Writes win conflicts until the read has lost STARVE_LIMIT times in a row.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int              ADDR_W       = ADDR_W_DEF,
    parameter int              DATA_W       = DATA_W_DEF,
    parameter int              MASK_W       = MASK_W_DEF,
    parameter int              STARVE_LIMIT = 4,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    output logic              init_done,
    input  logic              wreq_valid,
    output logic              wreq_ready,
    input  logic [ADDR_W-1:0] wreq_addr,
    input  logic [MASK_W-1:0] wreq_mask,
    input  logic [DATA_W-1:0] wreq_data,
    input  logic              rreq_valid,
    output logic              rreq_ready,
    input  logic [ADDR_W-1:0] rreq_addr,
    output logic              rresp_valid,
    output logic [DATA_W-1:0] rresp_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              rresp_valid_q, rresp_valid_d;
    logic              grant_r, grant_w;
    logic              sweep_start, sweep_run, sweep_last, sweep_done;
    logic [ADDR_W-1:0] sweep_ptr;

    assign sweep_run   = (state_q == ST_INIT);
    assign sweep_start = (state_q == ST_READY) && clear_req;

    sram_init_sweeper #(
        .ADDR_W (ADDR_W)
    ) u_sweeper (
        .clock (clock),
        .reset (reset),
        .start (sweep_start),
        .run   (sweep_run),
        .ptr   (sweep_ptr),
        .last  (sweep_last),
        .done  (sweep_done)
    );

    // Next state, grant decision, starvation count and macro port drive.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        grant_r    = 1'b0;
        grant_w    = 1'b0;
        init_done  = 1'b0;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        case (state_q)
            ST_INIT: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_wmask = '1;
                sram_wdata = INIT_VAL;
                sram_addr  = sweep_ptr;
                if (sweep_last) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                init_done = sweep_done;
                if (clear_req) begin
                    state_d = ST_INIT;
                end else begin
                    grant_r = rreq_valid && (!wreq_valid || (starve_q == STARVE_MAX));
                    grant_w = wreq_valid && !grant_r;
                end
                if (grant_w) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = wreq_addr;
                    sram_wmask = wreq_mask;
                    sram_wdata = wreq_data;
                end else if (grant_r) begin
                    sram_en    = 1'b1;
                    sram_addr  = rreq_addr;
                end
            end
            default: state_d = ST_INIT;
        endcase
        // The count only tracks an unbroken run of lost conflicts.
        if (grant_r || !rreq_valid) begin
            starve_d = '0;
        end else if (grant_w && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
        rresp_valid_d = grant_r;
    end

    // State, starvation counter and read-response flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_INIT;
            starve_q      <= '0;
            rresp_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            rresp_valid_q <= rresp_valid_d;
        end
    end

    assign wreq_ready  = grant_w;
    assign rreq_ready  = grant_r;
    assign rresp_valid = rresp_valid_q;
    assign rresp_data  = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised and directed checks of the SRAM port arbiter against a
// behavioural memory model and a read-response scoreboard.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int AW = 12;
    localparam int DW = 96;
    localparam int MW = 16;
    localparam int LW = DW / MW;
    localparam int DEPTH = 4096;
    localparam int LIMIT = 4;
    localparam logic [DW-1:0] IVAL = 96'hA5C3_0F96_1E2D_3C4B_5A69_7887;

    logic          clock = 1'b0;
    logic          reset, clear_req, init_done;
    logic          wreq_valid, wreq_ready, rreq_valid, rreq_ready, rresp_valid;
    logic [AW-1:0] wreq_addr, rreq_addr, sram_addr;
    logic [MW-1:0] wreq_mask, sram_wmask;
    logic [DW-1:0] wreq_data, rresp_data, sram_wdata, sram_rdata;
    logic          sram_en, sram_wmode;

    always #5 clock = ~clock;

    sram_port_arbiter #(
        .ADDR_W (AW), .DATA_W (DW), .MASK_W (MW),
        .STARVE_LIMIT (LIMIT), .INIT_VAL (IVAL)
    ) dut (
        .clock (clock), .reset (reset), .clear_req (clear_req), .init_done (init_done),
        .wreq_valid (wreq_valid), .wreq_ready (wreq_ready), .wreq_addr (wreq_addr),
        .wreq_mask (wreq_mask), .wreq_data (wreq_data),
        .rreq_valid (rreq_valid), .rreq_ready (rreq_ready), .rreq_addr (rreq_addr),
        .rresp_valid (rresp_valid), .rresp_data (rresp_data),
        .sram_addr (sram_addr), .sram_en (sram_en), .sram_wmode (sram_wmode),
        .sram_wmask (sram_wmask), .sram_wdata (sram_wdata), .sram_rdata (sram_rdata)
    );

    // Behavioural SRAM macro: masked write, registered read data.
    logic [DW-1:0] mac_mem [DEPTH];
    logic [DW-1:0] mac_rdata;

    function automatic logic [DW-1:0] expand(input logic [MW-1:0] m);
        logic [DW-1:0] e;
        for (int b = 0; b < DW; b++) e[b] = m[b / LW];
        return e;
    endfunction

    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode)
                mac_mem[sram_addr] <= (mac_mem[sram_addr] & ~expand(sram_wmask)) | (sram_wdata & expand(sram_wmask));
            else
                mac_rdata <= mac_mem[sram_addr];
        end
    end
    assign sram_rdata = mac_rdata;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int  left, wins, both_seen;
    int  total = 0, bad = 0;
    bit  clr, rst_now, w_pend, r_pend, dut_rr;
    wreq_t w_req;
    rreq_t r_req;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic ref_fill();
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = IVAL;
    endtask

    task automatic new_write(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
        w_pend = 1'b1; w_req.addr = a; w_req.mask = m; w_req.data = d;
    endtask

    task automatic new_read(input logic [AW-1:0] a);
        r_pend = 1'b1; r_req.addr = a;
    endtask

    // One clock cycle: drive, sample at negedge, compare, advance the model.
    task automatic do_cycle();
        bit exp_r, exp_w;
        logic [125:0] av, ev;
        exp_t e;
        reset = rst_now; clear_req = clr;
        wreq_valid = w_pend; wreq_addr = w_req.addr; wreq_mask = w_req.mask; wreq_data = w_req.data;
        rreq_valid = r_pend; rreq_addr = r_req.addr;
        @(negedge clock);
        exp_r = 1'b0; exp_w = 1'b0;
        dut_rr = rreq_ready;
        if (rreq_ready && wreq_ready) both_seen++;
        if (left > 0) begin
            check(sram_addr == AW'(DEPTH - left), "sweep_addr", 128'(sram_addr), 128'(DEPTH - left));
            check({init_done, sram_en, sram_wmode, sram_wmask} == {3'b011, 16'hFFFF}, "sweep_ctl",
                  128'({init_done, sram_en, sram_wmode, sram_wmask}), 128'({3'b011, 16'hFFFF}));
            check(sram_wdata == IVAL, "sweep_data", 128'(sram_wdata), 128'(IVAL));
            check({rreq_ready, wreq_ready} == 2'b00, "ready_blocked", 128'({rreq_ready, wreq_ready}), 128'(0));
        end else begin
            check(init_done == 1'b1, "init_done", 128'(init_done), 128'(1));
            if (!clr) begin
                exp_r = r_pend && (!w_pend || wins == LIMIT);
                exp_w = w_pend && !exp_r;
            end
            check({rreq_ready, wreq_ready} == {exp_r, exp_w}, "grant",
                  128'({rreq_ready, wreq_ready}), 128'({exp_r, exp_w}));
            if (exp_w) begin
                ev = {2'b11, w_req.addr, w_req.mask, w_req.data};
                av = {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata};
            end else if (exp_r) begin
                ev = {2'b10, r_req.addr, 112'b0};
                av = {sram_en, sram_wmode, sram_addr, 112'b0};
            end else begin
                ev = '0;
                av = {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata};
            end
            check(av == ev, "sram_port", 128'(av), 128'(ev));
        end
        if (!r_pend || exp_r) wins = 0;
        else if (exp_w && wins < LIMIT) wins++;
        if (exp_w) begin
            for (int l = 0; l < MW; l++)
                if (w_req.mask[l]) ref_mem[w_req.addr][l*LW +: LW] = w_req.data[l*LW +: LW];
            $display("[%0d] write addr=%h mask=%h data=%h", cyc, w_req.addr, w_req.mask, w_req.data);
            w_pend = 1'b0;
        end
        if (exp_r) begin
            if (!rst_now) begin
                e.due = cyc + 1; e.addr = r_req.addr; e.data = ref_mem[r_req.addr];
                sbq.push_back(e);
            end
            $display("[%0d] read  addr=%h", cyc, r_req.addr);
            r_pend = 1'b0;
        end
        if (rst_now) begin
            left = DEPTH; wins = 0; ref_fill();
        end else if (left > 0) begin
            left--;
        end else if (clr) begin
            left = DEPTH; ref_fill();
        end
        clr = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (w_pend || r_pend); k++) do_cycle();
        do_cycle();
        do_cycle();
    endtask

    task automatic sweep_until(input int target);
        for (int k = 0; k < DEPTH + 10 && left != target; k++) do_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] pat;
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clock);
                    while (sbq.size() > 0 && sbq[0].due < cyc) begin
                        e = sbq.pop_front();
                        check(1'b0, "resp_missing", 128'(0), 128'(e.due));
                    end
                    if (rresp_valid) begin
                        if (sbq.size() == 0) begin
                            check(1'b0, "resp_spurious", 128'(1), 128'(0));
                        end else begin
                            e = sbq.pop_front();
                            check(e.due == cyc, "resp_time", 128'(cyc), 128'(e.due));
                            check(rresp_data == e.data, "resp_data", 128'(rresp_data), 128'(e.data));
                            $display("[%0d] resp  addr=%h data=%h", cyc, e.addr, rresp_data);
                        end
                    end
                end
            end
        join_none

        reset = 1'b1; clear_req = 1'b0; wreq_valid = 1'b0; rreq_valid = 1'b0;
        wreq_addr = '0; wreq_mask = '0; wreq_data = '0; rreq_addr = '0;
        w_req = '0; r_req = '0; w_pend = 0; r_pend = 0; clr = 0; wins = 0; both_seen = 0;
        repeat (2) @(posedge clock);
        #1;
        check({init_done, rresp_valid, rreq_ready, wreq_ready} == 4'b0000, "reset_state",
              128'({init_done, rresp_valid, rreq_ready, wreq_ready}), 128'(0));
        left = DEPTH; ref_fill();
        // Requests raised during reset and sweep must stay blocked.
        new_write(12'h3, 16'h00F0, {$urandom(), $urandom(), $urandom()});
        new_read(12'h3);
        rst_now = 1'b1;
        do_cycle();
        do_cycle();
        rst_now = 1'b0;
        sweep_until(0);
        drain();

        // Single-lane write then read back.
        new_write(12'h0A5, 16'h0001, 96'h3F);
        do_cycle();
        new_read(12'h0A5);
        do_cycle();
        drain();

        // Read, write same address, read again.
        new_read(12'h010);
        do_cycle();
        new_write(12'h010, 16'hFFFF, '1);
        do_cycle();
        new_read(12'h010);
        do_cycle();
        drain();

        // Continuous conflict: read must get through every fifth cycle.
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            if (!w_pend) new_write(AW'($urandom_range(0, 31)), MW'($urandom()), {$urandom(), $urandom(), $urandom()});
            if (!r_pend) new_read(AW'($urandom_range(0, 31)));
            do_cycle();
            pat[i] = dut_rr;
        end
        check(pat == 10'b10_0001_0000, "starve_pattern", 128'(pat), 128'(10'b10_0001_0000));
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (!w_pend && $urandom_range(0, 2) == 0)
                new_write(AW'($urandom_range(0, 31)), MW'($urandom()), {$urandom(), $urandom(), $urandom()});
            if (!r_pend && $urandom_range(0, 1) == 0)
                new_read(AW'($urandom_range(0, 31)));
            do_cycle();
        end
        drain();

        // Clear right after a read grant; response still delivered.
        new_read(12'h005);
        do_cycle();
        check(rresp_valid == 1'b1, "resp_at_clear", 128'(rresp_valid), 128'(1));
        clr = 1'b1;
        new_read(12'h006);
        do_cycle();
        sweep_until(DEPTH - 1000);
        clr = 1'b1;
        do_cycle();
        sweep_until(DEPTH - 2000);
        rst_now = 1'b1;
        do_cycle();
        rst_now = 1'b0;
        sweep_until(0);
        drain();

        // Everything written earlier must read back as the sweep value.
        for (int a = 0; a < 32; a++) begin
            new_read(AW'(a));
            do_cycle();
        end
        new_read(12'h0A5);
        do_cycle();
        new_read(12'h010);
        do_cycle();
        drain();

        // Reset in the cycle a read is granted: no response follows.
        new_read(12'h007);
        rst_now = 1'b1;
        do_cycle();
        rst_now = 1'b0;
        check(rresp_valid == 1'b0, "rst_drops_resp", 128'(rresp_valid), 128'(0));
        sweep_until(0);
        new_read(12'h007);
        do_cycle();
        drain();

        check(sbq.size() == 0, "resp_left", 128'(sbq.size()), 128'(0));
        check(both_seen == 0, "ready_exclusive", 128'(both_seen), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
